vc_test_rand_stall_sink: RTL and testbench

VC_TEST_RAND_STALL_SINK -- requirements
Module: vc_test_rand_stall_sink

---
 rtl/vc_test_rand_stall_sink.sv | 144 ++++++++++++++
 tb/tb_vc_test_rand_stall_sink.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_rand_stall_sink.sv
// vc_test_rand_stall_sink
//   Test sink for a valid/ready stream. A list of expected messages is loaded
//   through the ld_* port. Messages arriving on the in_* port are compared
//   against that list in order. After each accepted message the sink inserts
//   a pseudo-random number of stall cycles, drawn from a 32-bit Galois LFSR.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
//   both high in that cycle. ready never depends on valid in the same cycle.
//
// Ports
//   clk, reset       : clock; asynchronous active-high reset
//   ld_val/ld_rdy    : expected-message load handshake, ld_msg is the payload
//   in_val/in_rdy    : stream handshake, in_msg is the payload
//   done             : every loaded message has been received
//   recv_cnt         : number of accepted stream messages
//   err_count        : number of mismatches (saturating)
//   err_idx          : receive index of the first mismatch, 0 if none
//   dbg_state        : current FSM state (0 READY, 1 STALL, 2 HALT)
//
// Optional feature (macro VC_TEST_RAND_STALL_SINK_HALT_EN): the first
//   mismatching message halts the stream side until reset; loads continue.
module vc_test_rand_stall_sink #(
  parameter int unsigned p_msg_sz    = 8,
  parameter int unsigned p_max_delay = 0,
  parameter int unsigned p_num_msgs  = 16,
  parameter logic [31:0] p_seed      = 32'hdeadbeef
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_val,
  output logic                ld_rdy,
  input  logic [p_msg_sz-1:0] ld_msg,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  output logic                done,
  output logic [31:0]         recv_cnt,
  output logic [31:0]         err_count,
  output logic [31:0]         err_idx,
  output logic [1:0]          dbg_state
);

  localparam int          AW   = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] SEED = (p_seed == 32'd0) ? 32'd1 : p_seed;
  localparam logic [31:0] MASK = 32'h80200003;
  localparam logic [31:0] NUM  = 32'(p_num_msgs);
  localparam logic [31:0] MOD  = 32'(p_max_delay) + 32'd1;

  typedef enum logic [1:0] {
    READY = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   stall_q, stall_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   ld_cnt_q, ld_cnt_d;
  logic [31:0]   recv_cnt_q, recv_cnt_d;
  logic [31:0]   err_count_q, err_count_d;
  logic [31:0]   err_idx_q, err_idx_d;

  logic [p_msg_sz-1:0] mem [p_num_msgs];

  logic          ld_xfer;
  logic          in_xfer;
  logic          mismatch;
  logic [31:0]   delay;

  assign ld_rdy   = (ld_cnt_q < NUM);
  assign in_rdy   = (state_q == READY) && (recv_cnt_q < ld_cnt_q);
  assign done     = (ld_cnt_q != 32'd0) && (recv_cnt_q == ld_cnt_q);
  assign ld_xfer  = ld_val && ld_rdy;
  assign in_xfer  = in_val && in_rdy;
  // recv_cnt_q < ld_cnt_q <= p_num_msgs whenever in_xfer is high, so the
  // truncated index always addresses a written entry.
  assign mismatch = in_xfer && (in_msg != mem[recv_cnt_q[AW-1:0]]);
  assign delay    = lfsr_q % MOD;

  assign recv_cnt  = recv_cnt_q;
  assign err_count = err_count_q;
  assign err_idx   = err_idx_q;
  assign dbg_state = state_q;

  // Right-shifting Galois LFSR; free-running out of reset.
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? MASK : 32'd0);

  assign ld_cnt_d    = ld_cnt_q + {31'd0, ld_xfer};
  assign recv_cnt_d  = recv_cnt_q + {31'd0, in_xfer};
  assign err_count_d = (mismatch && (err_count_q != 32'hffffffff)) ?
                       err_count_q + 32'd1 : err_count_q;
  assign err_idx_d   = (mismatch && (err_count_q == 32'd0)) ? recv_cnt_q : err_idx_q;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    case (state_q)
      READY: begin
        if (in_xfer) begin
          if (delay != 32'd0) begin
            stall_d = delay;
            state_d = STALL;
          end
`ifdef VC_TEST_RAND_STALL_SINK_HALT_EN
          if (mismatch) state_d = HALT;
`endif
        end
      end
      STALL: begin
        // Entered with stall_q = d, leaves after d cycles in this state.
        stall_d = stall_q - 32'd1;
        if (stall_q <= 32'd1) state_d = READY;
      end
      HALT:    state_d = HALT;
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= READY;
      stall_q     <= 32'd0;
      lfsr_q      <= SEED;
      ld_cnt_q    <= 32'd0;
      recv_cnt_q  <= 32'd0;
      err_count_q <= 32'd0;
      err_idx_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      lfsr_q      <= lfsr_d;
      ld_cnt_q    <= ld_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      err_count_q <= err_count_d;
      err_idx_q   <= err_idx_d;
    end
  end

  // Expected-message storage; contents are irrelevant until loaded.
  always_ff @(posedge clk) begin
    if (ld_xfer) mem[ld_cnt_q[AW-1:0]] <= ld_msg;
  end

endmodule

// File: tb/tb_vc_test_rand_stall_sink.sv
// Bench for vc_test_rand_stall_sink. Instance a uses random stalls (max 3,
// depth 128) and runs against a cycle-level reference model; instance b uses
// no stalls (depth 4) for directed scenarios.
module tb_vc_test_rand_stall_sink;

  localparam logic [31:0] SEED  = 32'hdeadbeef;
  localparam int          A_NUM = 128;

  logic        clk;
  logic        reset;

  logic        a_ld_val, a_ld_rdy, a_in_val, a_in_rdy, a_done;
  logic [7:0]  a_ld_msg, a_in_msg;
  logic [31:0] a_recv_cnt, a_err_count, a_err_idx;
  logic [1:0]  a_dbg;

  logic        b_ld_val, b_ld_rdy, b_in_val, b_in_rdy, b_done;
  logic [7:0]  b_ld_msg, b_in_msg;
  logic [31:0] b_recv_cnt, b_err_count, b_err_idx;
  logic [1:0]  b_dbg;

  int tests_run;
  int tests_failed;

  vc_test_rand_stall_sink #(.p_msg_sz(8), .p_max_delay(3), .p_num_msgs(A_NUM), .p_seed(SEED)) dut_a (
    .clk(clk), .reset(reset),
    .ld_val(a_ld_val), .ld_rdy(a_ld_rdy), .ld_msg(a_ld_msg),
    .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
    .done(a_done), .recv_cnt(a_recv_cnt), .err_count(a_err_count), .err_idx(a_err_idx),
    .dbg_state(a_dbg)
  );

  vc_test_rand_stall_sink #(.p_msg_sz(8), .p_max_delay(0), .p_num_msgs(4), .p_seed(SEED)) dut_b (
    .clk(clk), .reset(reset),
    .ld_val(b_ld_val), .ld_rdy(b_ld_rdy), .ld_msg(b_ld_msg),
    .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
    .done(b_done), .recv_cnt(b_recv_cnt), .err_count(b_err_count), .err_idx(b_err_idx),
    .dbg_state(b_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model for instance a ----------------
  logic [7:0]  exp_q[$];       // loaded messages, in receive order
  logic [31:0] m_lfsr;
  int          m_cyc;          // cycles elapsed since reset release
  int          m_ready_at;     // first cycle the sink may accept again
  int          m_recv;
  int          m_err;
  int          m_idx;
  bit          m_halted;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    a_ld_val = 1'b0; a_ld_msg = 8'h0; a_in_val = 1'b0; a_in_msg = 8'h0;
    b_ld_val = 1'b0; b_ld_msg = 8'h0; b_in_val = 1'b0; b_in_msg = 8'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_a_in_rdy", 32'(a_in_rdy), 32'd0);
    check("rst_a_ld_rdy", 32'(a_ld_rdy), 32'd1);
    check("rst_a_done",   32'(a_done),   32'd0);
    check("rst_a_recv",   a_recv_cnt,    32'd0);
    check("rst_a_err",    a_err_count,   32'd0);
    check("rst_a_idx",    a_err_idx,     32'd0);
    check("rst_b_in_rdy", 32'(b_in_rdy), 32'd0);
    check("rst_b_ld_rdy", 32'(b_ld_rdy), 32'd1);
    check("rst_b_done",   32'(b_done),   32'd0);
    reset = 1'b0;
    exp_q.delete();
    m_lfsr = SEED; m_cyc = 0; m_ready_at = 0;
    m_recv = 0; m_err = 0; m_idx = 0; m_halted = 1'b0;
  endtask

  // One cycle on instance a, entered and left at a falling edge.
  task automatic cycle_a(input logic lv, input logic [7:0] lm, input logic iv, input logic [7:0] im);
    logic er;
    er = !m_halted && (m_cyc >= m_ready_at) && (m_recv < exp_q.size());
    check("a_in_rdy", 32'(a_in_rdy),   32'(er));
    check("a_ld_rdy", 32'(a_ld_rdy),   32'(exp_q.size() < A_NUM));
    check("a_recv",   a_recv_cnt,      32'(m_recv));
    check("a_err",    a_err_count,     32'(m_err));
    check("a_idx",    a_err_idx,       32'(m_idx));
    check("a_done",   32'(a_done),     32'((exp_q.size() != 0) && (m_recv == exp_q.size())));
    a_ld_val = lv; a_ld_msg = lm; a_in_val = iv; a_in_msg = im;
    @(posedge clk);
    if (iv && er) begin
      if (im != exp_q[m_recv]) begin
        if (m_err == 0) m_idx = m_recv;
        m_err++;
`ifdef VC_TEST_RAND_STALL_SINK_HALT_EN
        m_halted = 1'b1;
`endif
      end
      m_recv++;
      m_ready_at = m_cyc + 1 + int'(m_lfsr % 32'd4);
    end
    if (lv && (exp_q.size() < A_NUM)) exp_q.push_back(lm);
    m_lfsr = lfsr_step(m_lfsr);
    m_cyc++;
    @(negedge clk);
  endtask

  int gaps_cur[$];
  int gaps1[$];

  // 100 matching messages with in_val always high; records stall gaps.
  task automatic gap_run();
    int  gap;
    bit  started;
    logic obs;
    do_reset();
    for (int i = 0; i < 100; i++) cycle_a(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h0);
    gaps_cur.delete();
    gap = 0; started = 0;
    for (int n = 0; n < 1000 && m_recv < 100; n++) begin
      obs = a_in_rdy;
      cycle_a(1'b0, 8'h0, 1'b1, exp_q[m_recv]);
      if (obs) begin
        if (started) gaps_cur.push_back(gap);
        started = 1; gap = 0;
      end else begin
        gap++;
      end
    end
    check("gap_all_recv", a_recv_cnt,  32'd100);
    check("gap_done",     32'(a_done), 32'd1);
    check("gap_err",      a_err_count, 32'd0);
    check("gap_count",    32'(gaps_cur.size()), 32'd99);
  endtask

  // ---------------- instance b helpers ----------------
  task automatic cycle_b();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] msgs3 [3];

  initial begin
    tests_run = 0;
    tests_failed = 0;

    // ---- b: empty sink ignores in_val; load then receive next cycle ----
    do_reset();
    b_in_val = 1'b1; b_in_msg = 8'hA5;
    #1 check("b_empty_in_rdy", 32'(b_in_rdy), 32'd0);
    b_ld_val = 1'b1; b_ld_msg = 8'hA5;
    #1 check("b_load_cycle_in_rdy", 32'(b_in_rdy), 32'd0);
    cycle_b();
    b_ld_val = 1'b0;
    check("b_after_load_in_rdy", 32'(b_in_rdy), 32'd1);
    cycle_b();
    b_in_val = 1'b0;
    check("b_a5_recv", b_recv_cnt,  32'd1);
    check("b_a5_done", 32'(b_done), 32'd1);
    check("b_a5_err",  b_err_count, 32'd0);

    // ---- b: three back-to-back matching transfers ----
    do_reset();
    msgs3[0] = 8'h11; msgs3[1] = 8'h22; msgs3[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      b_ld_val = 1'b1; b_ld_msg = msgs3[i];
      cycle_b();
    end
    b_ld_val = 1'b0;
    b_in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b_b2b_in_rdy", 32'(b_in_rdy), 32'd1);
      check("b_b2b_done",   32'(b_done),   32'd0);
      b_in_msg = msgs3[i];
      cycle_b();
    end
    b_in_val = 1'b0;
    check("b_b2b_recv",   b_recv_cnt,     32'd3);
    check("b_b2b_done3",  32'(b_done),    32'd1);
    check("b_b2b_err",    b_err_count,    32'd0);
    check("b_b2b_in_rdy0", 32'(b_in_rdy), 32'd0);

    // ---- b: mismatch in the middle ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b_ld_val = 1'b1; b_ld_msg = msgs3[i];
      cycle_b();
    end
    b_ld_val = 1'b0;
    msgs3[1] = 8'h55;
    b_in_val = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b_in_msg = (b_recv_cnt < 32'd3) ? msgs3[b_recv_cnt[1:0]] : 8'h0;
      cycle_b();
    end
    b_in_val = 1'b0;
    check("b_mm_err", b_err_count, 32'd1);
    check("b_mm_idx", b_err_idx,   32'd1);
`ifdef VC_TEST_RAND_STALL_SINK_HALT_EN
    check("b_mm_recv",   b_recv_cnt,     32'd2);
    check("b_mm_done",   32'(b_done),    32'd0);
    check("b_mm_in_rdy", 32'(b_in_rdy),  32'd0);
    check("b_mm_state",  32'(b_dbg),     32'd2);
    b_ld_val = 1'b1; b_ld_msg = 8'h44;
    cycle_b();
    b_ld_val = 1'b0;
    check("b_halt_load_ld_rdy", 32'(b_ld_rdy), 32'd0);
`else
    check("b_mm_recv",   b_recv_cnt,     32'd3);
    check("b_mm_done",   32'(b_done),    32'd1);
    check("b_mm_state",  32'(b_dbg),     32'd0);
`endif

    // ---- b: loads beyond depth are ignored ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b_ld_val = 1'b1; b_ld_msg = 8'(i + 1);
      check("b_full_ld_rdy", 32'(b_ld_rdy), 32'(i < 4));
      cycle_b();
    end
    b_ld_val = 1'b0;
    b_in_val = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b_in_msg = b_recv_cnt[7:0] + 8'd1;
      cycle_b();
    end
    b_in_val = 1'b0;
    check("b_full_recv",   b_recv_cnt,     32'd4);
    check("b_full_done",   32'(b_done),    32'd1);
    check("b_full_err",    b_err_count,    32'd0);
    check("b_full_in_rdy", 32'(b_in_rdy),  32'd0);

    // ---- a: stall gaps, repeated with the same seed ----
    gap_run();
    gaps1 = gaps_cur;
    foreach (gaps1[i]) check("gap_range", 32'(gaps1[i] <= 3), 32'd1);
    gap_run();
    check("gap_len_same", 32'(gaps_cur.size()), 32'(gaps1.size()));
    for (int i = 0; i < gaps1.size() && i < gaps_cur.size(); i++)
      check("gap_repeat", 32'(gaps_cur[i]), 32'(gaps1[i]));

    // ---- a: random loads, random valid, occasional corrupt messages ----
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic       lv, iv;
      logic [7:0] im;
      lv = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 3) != 0);
      if ((m_recv < exp_q.size()) && ($urandom_range(0, 9) != 0)) im = exp_q[m_recv];
      else im = 8'($urandom_range(0, 255));
      cycle_a(lv, 8'($urandom_range(0, 255)), iv, im);
    end

    // ---- a: asynchronous reset mid-stream ----
    do_reset();
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 8'(8'h10 + i), 1'b0, 8'h0);
    for (int n = 0; n < 40 && m_recv < 2; n++) cycle_a(1'b0, 8'h0, 1'b1, exp_q[m_recv]);
    check("mid_recv_before", a_recv_cnt, 32'd2);
    a_in_val = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_recv",   a_recv_cnt,    32'd0);
    check("mid_rst_in_rdy", 32'(a_in_rdy), 32'd0);
    check("mid_rst_done",   32'(a_done),   32'd0);
    check("mid_rst_ld_rdy", 32'(a_ld_rdy), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
